// File: rtl/pipe_stage_skid_pkg.sv
// Shared definitions for the pipeline-stage registers.
// Contents:
//   OCC_W       - width of the occupancy report (0..2 beats)
//   CTRL_W_DEF  - default width of the control field
//   control-field bit positions, agreed on by every stage
//   occ_count() - occupancy from the two entry-valid flags
package pipe_pkg;

  localparam int OCC_W      = 2;
  localparam int CTRL_W_DEF = 24;

  // Control-field layout
  localparam int REGWR       = 0;
  localparam int MEMRD       = 1;
  localparam int MEMWR       = 2;
  localparam int MEMTOREG_LO = 3;   // MEMTOREG[1:0] at [4:3]
  localparam int MEMTOREG_W  = 2;
  localparam int ALUCTRL_LO  = 5;   // ALUCTRL[4:0] at [9:5]
  localparam int ALUCTRL_W   = 5;
  localparam int PCSRC_LO    = 10;  // PCSRC[1:0] at [11:10]
  localparam int PCSRC_W     = 2;

  function automatic logic [OCC_W-1:0] occ_count(input logic m_v, input logic s_v);
    return {1'b0, m_v} + {1'b0, s_v};
  endfunction

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating up-counter used for the stall performance counter.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous reset, active high (clears count)
//   clr  - synchronous clear, beats inc
//   inc  - count one event this cycle
//   cnt  - current count, sticks at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    if (v == {W{1'b1}}) return v;
    return v + {{(W-1){1'b0}}, 1'b1};
  endfunction

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= sat_inc(cnt);
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic pipeline-stage register with valid/ready handshake.
// SKID=1 adds a second (skid) entry so in_ready comes straight from a flop
// and never depends combinationally on out_ready; SKID=0 is a single
// register whose in_ready looks through to out_ready.
// Ports:
//   clk, rst               - clock and synchronous active-high reset
//   in_valid/in_ready      - upstream handshake, in_data/in_ctrl payload
//   flush                  - drop every held beat and any beat offered now
//   out_valid/out_ready    - downstream handshake
//   out_data/out_ctrl      - head entry; out_ctrl reads 0 on a bubble
//   occupancy              - held beats (0..2)
//   cnt_clr/stall_cnt      - stall counter clear / value
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W = 96,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [OCC_W-1:0]  occupancy,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic [CTRL_W-1:0] m_ctrl;
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic [CTRL_W-1:0] s_ctrl;

  logic in_fire;
  logic out_fire;

  always_comb begin
    if (SKID != 0) in_ready = !s_valid;
    else           in_ready = !m_valid || out_ready;
  end

  assign in_fire   = in_valid && in_ready;
  assign out_fire  = m_valid && out_ready;
  assign out_valid = m_valid;
  assign out_data  = m_data;
  assign out_ctrl  = m_valid ? m_ctrl : '0;
  assign occupancy = occ_count(m_valid, s_valid);

  // Entry update: reset, then flush, then the handshake moves.
  // The skid entry only ever fills while the main entry is full and
  // stalled, so s_valid always implies m_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_ctrl  <= '0;
      s_valid <= 1'b0;
      s_data  <= '0;
      s_ctrl  <= '0;
    end else if (flush) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (!m_valid) begin
      if (in_fire) begin
        m_valid <= 1'b1;
        m_data  <= in_data;
        m_ctrl  <= in_ctrl;
      end
    end else if (out_fire) begin
      if (s_valid) begin
        // in_ready is low here, so nothing new can arrive this cycle
        m_data  <= s_data;
        m_ctrl  <= s_ctrl;
        s_valid <= 1'b0;
      end else if (in_fire) begin
        m_data  <= in_data;
        m_ctrl  <= in_ctrl;
      end else begin
        m_valid <= 1'b0;
      end
    end else if (in_fire && (SKID != 0)) begin
      s_valid <= 1'b1;
      s_data  <= in_data;
      s_ctrl  <= in_ctrl;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (m_valid && !out_ready),
    .cnt (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

  logic clk;
  logic rst;

  // Instance A: SKID=1, 4-bit stall counter
  logic        a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready, a_cnt_clr;
  logic [95:0] a_in_data, a_out_data;
  logic [23:0] a_in_ctrl, a_out_ctrl;
  logic [1:0]  a_occ;
  logic [3:0]  a_stall;

  // Instance B: SKID=0, default counter
  logic        b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready, b_cnt_clr;
  logic [95:0] b_in_data, b_out_data;
  logic [23:0] b_in_ctrl, b_out_ctrl;
  logic [1:0]  b_occ;
  logic [15:0] b_stall;

  int checks = 0;
  int errors = 0;

  pipe_stage_skid #(.DATA_W(96), .CTRL_W(24), .SKID(1), .CNT_W(4)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_ctrl(a_in_ctrl),
    .flush(a_flush),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_ctrl(a_out_ctrl),
    .occupancy(a_occ), .cnt_clr(a_cnt_clr), .stall_cnt(a_stall)
  );

  pipe_stage_skid #(.DATA_W(96), .CTRL_W(24), .SKID(0), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_ctrl(b_in_ctrl),
    .flush(b_flush),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_ctrl(b_out_ctrl),
    .occupancy(b_occ), .cnt_clr(b_cnt_clr), .stall_cnt(b_stall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are examined 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (a_occ == 2'd2) chk("a_skid_implies_main", 128'(a_out_valid), 128'(1));
  endtask

  int exp_beat;
  int rcv;

  initial begin
    rst = 1'b1;
    a_in_valid = 0; a_in_data = '0; a_in_ctrl = '0; a_flush = 0; a_out_ready = 0; a_cnt_clr = 0;
    b_in_valid = 0; b_in_data = '0; b_in_ctrl = '0; b_flush = 0; b_out_ready = 0; b_cnt_clr = 0;
    tick();
    tick();

    // ---- reset state ----
    chk("rst_in_ready",  128'(a_in_ready), 128'(1));
    chk("rst_out_valid", 128'(a_out_valid), 128'(0));
    chk("rst_out_data",  128'(a_out_data), 128'(0));
    chk("rst_out_ctrl",  128'(a_out_ctrl), 128'(0));
    chk("rst_occ",       128'(a_occ), 128'(0));
    chk("rst_stall",     128'(a_stall), 128'(0));
    chk("rst_b_in_ready", 128'(b_in_ready), 128'(1));

    // ---- single beat ----
    rst = 1'b0;
    a_in_valid = 1; a_in_data = 96'h0000_0000_0000_1234_0000_0004; a_in_ctrl = 24'h000041;
    a_out_ready = 1;
    tick();
    chk("single_valid", 128'(a_out_valid), 128'(1));
    chk("single_data",  128'(a_out_data), 128'(96'h0000_0000_0000_1234_0000_0004));
    chk("single_ctrl",  128'(a_out_ctrl), 128'(24'h000041));
    chk("single_occ",   128'(a_occ), 128'(1));
    a_in_valid = 0;
    tick();
    chk("single_drain_valid", 128'(a_out_valid), 128'(0));
    chk("single_drain_ctrl",  128'(a_out_ctrl), 128'(0));
    chk("single_drain_occ",   128'(a_occ), 128'(0));

    // ---- back-pressure fill / drain ----
    a_out_ready = 0;
    a_in_valid = 1; a_in_data = 96'd1; a_in_ctrl = 24'h000001;
    tick();
    chk("bp_A_in_ready", 128'(a_in_ready), 128'(1));
    chk("bp_A_occ",      128'(a_occ), 128'(1));
    chk("bp_A_stall",    128'(a_stall), 128'(0));
    a_in_data = 96'd2; a_in_ctrl = 24'h000002;
    tick();
    chk("bp_B_in_ready", 128'(a_in_ready), 128'(0));
    chk("bp_B_occ",      128'(a_occ), 128'(2));
    chk("bp_B_stall",    128'(a_stall), 128'(1));
    a_in_data = 96'd3; a_in_ctrl = 24'h000003;
    tick();
    chk("bp_hold_data",  128'(a_out_data), 128'(1));
    chk("bp_hold_occ",   128'(a_occ), 128'(2));
    chk("bp_hold_stall", 128'(a_stall), 128'(2));
    a_out_ready = 1;
    tick();
    chk("bp_out_B",      128'(a_out_data), 128'(2));
    chk("bp_ready_back", 128'(a_in_ready), 128'(1));
    chk("bp_occ1",       128'(a_occ), 128'(1));
    chk("bp_stall_kept", 128'(a_stall), 128'(2));
    tick();
    chk("bp_out_C",      128'(a_out_data), 128'(3));
    chk("bp_out_C_ctrl", 128'(a_out_ctrl), 128'(3));
    a_in_valid = 0;
    tick();
    chk("bp_empty",      128'(a_out_valid), 128'(0));

    // ---- flush with full skid ----
    a_out_ready = 0;
    a_in_valid = 1; a_in_data = 96'h11; a_in_ctrl = 24'h000041;
    tick();
    a_in_data = 96'h22;
    tick();
    chk("fl_full_occ", 128'(a_occ), 128'(2));
    a_flush = 1; a_in_data = 96'd4;
    tick();
    chk("fl_out_valid", 128'(a_out_valid), 128'(0));
    chk("fl_out_ctrl",  128'(a_out_ctrl), 128'(0));
    chk("fl_occ",       128'(a_occ), 128'(0));
    chk("fl_in_ready",  128'(a_in_ready), 128'(1));
    chk("fl_stall_kept", 128'(a_stall), 128'(4));
    // flush while a beat really fires into an empty stage
    a_in_data = 96'd5;
    tick();
    chk("fl_fire_dropped", 128'(a_out_valid), 128'(0));
    a_flush = 0; a_in_valid = 0; a_out_ready = 1;
    tick();
    chk("fl_D_never", 128'(a_out_valid), 128'(0));
    a_cnt_clr = 1;
    tick();
    chk("clr_stall", 128'(a_stall), 128'(0));
    a_cnt_clr = 0;

    // ---- full throughput ----
    exp_beat = 100;
    rcv = 0;
    for (int i = 0; i < 100; i++) begin
      a_in_valid = 1; a_in_data = 96'(i + 100); a_in_ctrl = 24'(i + 1);
      tick();
      if (a_out_valid) begin
        chk("thr_data", 128'(a_out_data), 128'(exp_beat));
        exp_beat++;
        rcv++;
      end
    end
    a_in_valid = 0;
    tick();
    chk("thr_count", 128'(rcv), 128'(100));
    chk("thr_idle",  128'(a_out_valid), 128'(0));
    chk("thr_stall", 128'(a_stall), 128'(0));

    // ---- counter saturation / clear ----
    a_out_ready = 0;
    a_in_valid = 1; a_in_data = 96'h77;
    tick();
    a_in_valid = 0;
    for (int i = 0; i < 20; i++) tick();
    chk("sat_value", 128'(a_stall), 128'(15));
    a_cnt_clr = 1;
    tick();
    chk("sat_clr", 128'(a_stall), 128'(0));
    a_cnt_clr = 0;
    tick();
    chk("sat_restart", 128'(a_stall), 128'(1));

    // ---- SKID=0 variant ----
    b_out_ready = 0;
    b_in_valid = 1; b_in_data = 96'd7; b_in_ctrl = 24'h000007;
    #1;
    chk("b_ready_empty", 128'(b_in_ready), 128'(1));
    tick();
    chk("b_ready_full", 128'(b_in_ready), 128'(0));
    chk("b_occ1",       128'(b_occ), 128'(1));
    tick();
    chk("b_hold_data",  128'(b_out_data), 128'(7));
    chk("b_occ_le1",    128'(b_occ <= 2'd1), 128'(1));
    b_out_ready = 1; b_in_data = 96'd8;
    #1;
    chk("b_ready_comb", 128'(b_in_ready), 128'(1));
    tick();
    chk("b_beat8", 128'(b_out_data), 128'(8));
    b_in_data = 96'd9;
    tick();
    chk("b_beat9", 128'(b_out_data), 128'(9));
    b_in_data = 96'd10;
    tick();
    chk("b_beat10", 128'(b_out_data), 128'(10));
    chk("b_occ_stream", 128'(b_occ), 128'(1));
    b_in_valid = 0;
    tick();
    chk("b_drain", 128'(b_out_valid), 128'(0));
    chk("b_stall", 128'(b_stall), 128'(1));

    // ---- reset overrides everything ----
    a_out_ready = 0;
    a_in_valid = 1; a_in_data = 96'h55;
    tick();
    tick();
    chk("rst2_pre_occ", 128'(a_occ), 128'(2));
    rst = 1; a_flush = 0; a_cnt_clr = 0;
    tick();
    chk("rst2_occ",   128'(a_occ), 128'(0));
    chk("rst2_data",  128'(a_out_data), 128'(0));
    chk("rst2_stall", 128'(a_stall), 128'(0));
    chk("rst2_ready", 128'(a_in_ready), 128'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
